// File: rtl/gmii_rx_frame_align.sv
// GMII receive framer: strips preamble/SFD and emits a byte stream with sof/eof/err flags and saturating counters.
// Optional in-band link status outputs are enabled by defining GMII_RX_INBAND_STATUS_EN.
module gmii_rx_frame_align #(
    parameter int         MAX_PREAMBLE   = 7,
    parameter int         CNT_W          = 16,
    parameter logic [1:0] BYTE_MODE_CODE = 2'b10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       speed_mode,
    input  logic             gmii_rx_dv,
    input  logic             gmii_rx_er,
    input  logic [7:0]       gmii_rxd,
    output logic             out_valid,
    output logic [7:0]       out_data,
    output logic             out_sof,
    output logic             out_eof,
    output logic             out_err,
    output logic [CNT_W-1:0] frame_cnt,
    output logic [CNT_W-1:0] err_cnt
`ifdef GMII_RX_INBAND_STATUS_EN
    ,
    output logic             link_up,
    output logic [1:0]       link_speed,
    output logic             link_duplex
`endif
);

    localparam int PW = $clog2(2 * MAX_PREAMBLE + 3);
    localparam logic [PW-1:0] MAXP = PW'(MAX_PREAMBLE);

    typedef enum logic [1:0] {S_IDLE, S_PREAMBLE, S_DATA, S_DROP} state_t;

    state_t          r_state;
    logic            r_dv_q;
    logic            r_byte_mode;
    logic            r_phase;
    logic [3:0]      r_nib_lo;
    logic [7:0]      r_hold;
    logic            r_hold_full;
    logic            r_first;
    logic            r_err;
    logic [PW-1:0]   r_pre_cnt;

    logic            w_start;
    logic            w_mode_byte;
    logic            w_pre_step;
    logic [PW-1:0]   w_cnt_next;
    logic [PW-1:0]   w_pre_bytes;
    logic            w_ovf;
    logic            w_is_pre;
    logic            w_is_sfd;
    logic [7:0]      w_byte;
    logic            w_eof_err;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // The dv-rising symbol is itself the first preamble symbol, so it is evaluated from IDLE.
    always_comb begin
        w_start     = (r_state == S_IDLE) && gmii_rx_dv && !r_dv_q;
        w_mode_byte = (r_state == S_IDLE) ? (speed_mode == BYTE_MODE_CODE) : r_byte_mode;
        w_cnt_next  = ((r_state == S_IDLE) ? '0 : r_pre_cnt) + PW'(1);
        w_pre_bytes = w_mode_byte ? w_cnt_next : (w_cnt_next >> 1);
        w_ovf       = w_pre_bytes > MAXP;
        w_is_pre    = w_mode_byte ? (gmii_rxd == 8'h55) : (gmii_rxd[3:0] == 4'h5);
        w_is_sfd    = w_mode_byte ? (gmii_rxd == 8'hD5) : (gmii_rxd[3:0] == 4'hD);
        w_pre_step  = w_start || ((r_state == S_PREAMBLE) && gmii_rx_dv);
        w_byte      = r_byte_mode ? gmii_rxd : {gmii_rxd[3:0], r_nib_lo};
        w_eof_err   = r_err || (!r_byte_mode && r_phase);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_dv_q      <= 1'b1;
            r_byte_mode <= 1'b0;
            r_phase     <= 1'b0;
            r_nib_lo    <= '0;
            r_hold      <= '0;
            r_hold_full <= 1'b0;
            r_first     <= 1'b0;
            r_err       <= 1'b0;
            r_pre_cnt   <= '0;
            out_valid   <= 1'b0;
            out_data    <= '0;
            out_sof     <= 1'b0;
            out_eof     <= 1'b0;
            out_err     <= 1'b0;
            frame_cnt   <= '0;
            err_cnt     <= '0;
        end else begin
            r_dv_q    <= gmii_rx_dv;
            out_valid <= 1'b0;
            out_sof   <= 1'b0;
            out_eof   <= 1'b0;
            out_err   <= 1'b0;
            case (r_state)
                S_IDLE, S_PREAMBLE: begin
                    if (w_pre_step) begin
                        r_byte_mode <= w_mode_byte;
                        if (w_is_sfd) begin
                            r_state     <= S_DATA;
                            r_phase     <= 1'b0;
                            r_hold_full <= 1'b0;
                            r_first     <= 1'b1;
                            r_err       <= 1'b0;
                        end else if (w_is_pre && !w_ovf) begin
                            r_state   <= S_PREAMBLE;
                            r_pre_cnt <= w_cnt_next;
                        end else begin
                            r_state <= S_DROP;
                            err_cnt <= sat_inc(err_cnt);
                        end
                    end else if (r_state == S_PREAMBLE) begin
                        r_state <= S_IDLE;
                    end
                end
                S_DATA: begin
                    if (gmii_rx_dv) begin
                        r_err <= r_err || gmii_rx_er;
                        if (!r_byte_mode && !r_phase) begin
                            r_nib_lo <= gmii_rxd[3:0];
                            r_phase  <= 1'b1;
                        end else begin
                            r_phase     <= 1'b0;
                            r_hold      <= w_byte;
                            r_hold_full <= 1'b1;
                            if (r_hold_full) begin
                                out_valid <= 1'b1;
                                out_data  <= r_hold;
                                out_sof   <= r_first;
                                r_first   <= 1'b0;
                            end
                        end
                    end else begin
                        r_state <= S_IDLE;
                        if (r_hold_full) begin
                            out_valid <= 1'b1;
                            out_data  <= r_hold;
                            out_sof   <= r_first;
                            out_eof   <= 1'b1;
                            out_err   <= w_eof_err;
                            frame_cnt <= sat_inc(frame_cnt);
                            if (w_eof_err) err_cnt <= sat_inc(err_cnt);
                        end
                    end
                end
                S_DROP: begin
                    if (!gmii_rx_dv) r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

`ifdef GMII_RX_INBAND_STATUS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            link_up     <= 1'b0;
            link_speed  <= '0;
            link_duplex <= 1'b0;
        end else if (!gmii_rx_dv && !gmii_rx_er) begin
            link_up     <= gmii_rxd[0];
            link_speed  <= gmii_rxd[2:1];
            link_duplex <= gmii_rxd[3];
        end
    end
`endif

endmodule

// File: tb/tb_gmii_rx_frame_align.sv
// Self-checking bench for gmii_rx_frame_align: directed vector tables plus random frames against a frame-level model.
// Link status checks are included when GMII_RX_INBAND_STATUS_EN is defined.
module tb_gmii_rx_frame_align;

    localparam int MAXP = 7;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  speed_mode = 2'b10;
    logic        gmii_rx_dv = 1'b0;
    logic        gmii_rx_er = 1'b0;
    logic [7:0]  gmii_rxd = '0;
    logic        out_valid, out_sof, out_eof, out_err;
    logic [7:0]  out_data;
    logic [15:0] frame_cnt, err_cnt;
    logic        s_valid, s_sof, s_eof, s_err;
    logic [7:0]  s_data;
    logic [1:0]  s_frame_cnt, s_err_cnt;
`ifdef GMII_RX_INBAND_STATUS_EN
    logic        link_up, link_duplex, s_link_up, s_link_duplex;
    logic [1:0]  link_speed, s_link_speed;
`endif

    always #5 clk = ~clk;

    gmii_rx_frame_align #(.MAX_PREAMBLE(7), .CNT_W(16), .BYTE_MODE_CODE(2'b10)) dut (
        .clk(clk), .rst_n(rst_n), .speed_mode(speed_mode), .gmii_rx_dv(gmii_rx_dv),
        .gmii_rx_er(gmii_rx_er), .gmii_rxd(gmii_rxd), .out_valid(out_valid), .out_data(out_data),
        .out_sof(out_sof), .out_eof(out_eof), .out_err(out_err), .frame_cnt(frame_cnt), .err_cnt(err_cnt)
`ifdef GMII_RX_INBAND_STATUS_EN
        , .link_up(link_up), .link_speed(link_speed), .link_duplex(link_duplex)
`endif
    );

    gmii_rx_frame_align #(.MAX_PREAMBLE(7), .CNT_W(2), .BYTE_MODE_CODE(2'b10)) dut_sat (
        .clk(clk), .rst_n(rst_n), .speed_mode(speed_mode), .gmii_rx_dv(gmii_rx_dv),
        .gmii_rx_er(gmii_rx_er), .gmii_rxd(gmii_rxd), .out_valid(s_valid), .out_data(s_data),
        .out_sof(s_sof), .out_eof(s_eof), .out_err(s_err), .frame_cnt(s_frame_cnt), .err_cnt(s_err_cnt)
`ifdef GMII_RX_INBAND_STATUS_EN
        , .link_up(s_link_up), .link_speed(s_link_speed), .link_duplex(s_link_duplex)
`endif
    );

    typedef struct {
        logic [1:0] spd;
        logic       dv;
        logic       er;
        logic [7:0] d;
        logic       ev;
        logic [7:0] ed;
        logic       esof;
        logic       eeof;
        logic       eerr;
        logic       edrop;
    } vec_t;

    vec_t       q[$];
    logic [7:0] pbuf[16];
    int         total = 0;
    int         bad = 0;
    int         m_frames = 0;
    int         m_errs = 0;
    logic       m_up = 1'b0;
    logic [1:0] m_spd = '0;
    logic       m_dup = 1'b0;

    function automatic vec_t mk(input logic [1:0] spd, input logic dv, input logic er, input logic [7:0] d);
        vec_t v;
        v.spd = spd; v.dv = dv; v.er = er; v.d = d;
        v.ev = 1'b0; v.ed = '0; v.esof = 1'b0; v.eeof = 1'b0; v.eerr = 1'b0; v.edrop = 1'b0;
        return v;
    endfunction

    function automatic int sat3(input int x);
        return (x > 3) ? 3 : x;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    task automatic add_gap(input logic [1:0] spd, input int n);
        for (int i = 0; i < n; i++) q.push_back(mk(spd, 1'b0, 1'b0, 8'($urandom)));
    endtask

    // Frame-level model: decide drop/accept from the preamble symbols, then place each payload
    // byte on the cycle that completes the following byte (last byte on the first idle cycle).
    task automatic add_frame(input logic [1:0] spd, input int npre, input int bad_at, input logic [7:0] bad_sym,
                             input bit sfd, input int n, input int er_at, input bit odd, input int gap);
        bit nib;
        int base, cnt, drop_i, ds, ge, per, ndata, idx;
        logic [7:0] s;
        vec_t t;
        nib = (spd != 2'b10);
        per = nib ? 2 : 1;
        base = q.size();
        cnt = 0;
        drop_i = -1;
        ndata = 0;
        for (int i = 0; i < npre; i++) begin
            if (i == bad_at) s = bad_sym;
            else s = nib ? {4'($urandom), 4'h5} : 8'h55;
            if (drop_i < 0) begin
                if (i == bad_at) drop_i = i;
                else begin
                    cnt++;
                    if ((nib ? cnt / 2 : cnt) > MAXP) drop_i = i;
                end
            end
            q.push_back(mk(spd, 1'b1, 1'b0, s));
        end
        if (drop_i >= 0) begin
            t = q[base + drop_i]; t.edrop = 1'b1; q[base + drop_i] = t;
        end
        ds = q.size();
        if (sfd) begin
            q.push_back(mk(spd, 1'b1, 1'b0, nib ? {4'($urandom), 4'hD} : 8'hD5));
            ds = q.size();
            for (int j = 0; j < n; j++) begin
                if (nib) begin
                    q.push_back(mk(spd, 1'b1, 1'b0, {4'($urandom), pbuf[j][3:0]}));
                    q.push_back(mk(spd, 1'b1, 1'b0, {4'($urandom), pbuf[j][7:4]}));
                end else begin
                    q.push_back(mk(spd, 1'b1, 1'b0, pbuf[j]));
                end
            end
            if (nib && odd) q.push_back(mk(spd, 1'b1, 1'b0, 8'($urandom)));
            ndata = q.size() - ds;
            if (er_at >= 0 && er_at < ndata) begin
                t = q[ds + er_at]; t.er = 1'b1; q[ds + er_at] = t;
            end
        end
        ge = q.size();
        add_gap(spd, gap);
        if (drop_i < 0 && sfd && n > 0) begin
            for (int k = 0; k < n - 1; k++) begin
                idx = ds + per * (k + 1) + per - 1;
                t = q[idx]; t.ev = 1'b1; t.ed = pbuf[k]; t.esof = (k == 0); q[idx] = t;
            end
            t = q[ge];
            t.ev = 1'b1; t.ed = pbuf[n-1]; t.esof = (n == 1); t.eeof = 1'b1;
            t.eerr = (er_at >= 0 && er_at < ndata) || (nib && odd);
            q[ge] = t;
        end
    endtask

    task automatic apply(input vec_t v);
        speed_mode = v.spd;
        gmii_rx_dv = v.dv;
        gmii_rx_er = v.er;
        gmii_rxd   = v.d;
        @(posedge clk);
        #1;
        if (v.eeof) begin
            m_frames++;
            if (v.eerr) m_errs++;
        end
        if (v.edrop) m_errs++;
        chk("flags", {out_valid, out_sof, out_eof, out_eof & out_err},
            {v.ev, v.ev & v.esof, v.ev & v.eeof, v.ev & v.eeof & v.eerr});
        if (v.ev) chk("data", out_data, v.ed);
        chk("frame_cnt", frame_cnt, m_frames);
        chk("err_cnt", err_cnt, m_errs);
        chk("sat_frame_cnt", s_frame_cnt, sat3(m_frames));
        chk("sat_err_cnt", s_err_cnt, sat3(m_errs));
`ifdef GMII_RX_INBAND_STATUS_EN
        if (!v.dv && !v.er) begin
            m_up = v.d[0]; m_spd = v.d[2:1]; m_dup = v.d[3];
        end
        chk("link", {link_up, link_speed, link_duplex}, {m_up, m_spd, m_dup});
`endif
    endtask

    task automatic run_q();
        for (int i = 0; i < q.size(); i++) apply(q[i]);
        q.delete();
    endtask

    task automatic chk_reset_state();
        chk("rst_flags", {out_valid, out_sof, out_eof, out_err}, 4'h0);
        chk("rst_data", out_data, 8'h00);
        chk("rst_frame_cnt", frame_cnt, 0);
        chk("rst_err_cnt", err_cnt, 0);
`ifdef GMII_RX_INBAND_STATUS_EN
        chk("rst_link", {link_up, link_speed, link_duplex}, 4'h0);
`endif
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int npre, bad_at, n, er_at;
        bit nib, odd, sfd;
        logic [1:0] spd;
        logic [7:0] bs;

        repeat (3) @(posedge clk);
        #1;
        chk_reset_state();
        @(negedge clk);
        rst_n = 1'b1;

        // Byte-mode frame as a literal table: 7x55, D5, 11 22 33 44, dv falls.
        add_gap(2'b10, 2);
        for (int i = 0; i < 7; i++) q.push_back(mk(2'b10, 1'b1, 1'b0, 8'h55));
        q.push_back(mk(2'b10, 1'b1, 1'b0, 8'hD5));
        q.push_back(mk(2'b10, 1'b1, 1'b0, 8'h11));
        q.push_back(mk(2'b10, 1'b1, 1'b0, 8'h22)); q[$].ev = 1'b1; q[$].ed = 8'h11; q[$].esof = 1'b1;
        q.push_back(mk(2'b10, 1'b1, 1'b0, 8'h33)); q[$].ev = 1'b1; q[$].ed = 8'h22;
        q.push_back(mk(2'b10, 1'b1, 1'b0, 8'h44)); q[$].ev = 1'b1; q[$].ed = 8'h33;
        q.push_back(mk(2'b10, 1'b0, 1'b0, 8'h00)); q[$].ev = 1'b1; q[$].ed = 8'h44; q[$].eeof = 1'b1;
        q.push_back(mk(2'b10, 1'b0, 1'b0, 8'h00));
        run_q();
        chk("t1_frames", frame_cnt, 1);
        chk("t1_errs", err_cnt, 0);

        // Nibble mode 15x5, D, 1 2 3 4 -> 21 43.
        pbuf[0] = 8'h21; pbuf[1] = 8'h43;
        add_frame(2'b01, 15, -1, 8'h00, 1'b1, 2, -1, 1'b0, 3);
        // Byte mode with er on the second data byte.
        pbuf[0] = 8'hA1; pbuf[1] = 8'hB2; pbuf[2] = 8'hC3;
        add_frame(2'b10, 7, -1, 8'h00, 1'b1, 3, 1, 1'b0, 3);
        // Bad preamble byte, then over-long preambles (9 and 8 bytes, 16 nibbles).
        add_frame(2'b10, 2, 1, 8'h12, 1'b1, 3, -1, 1'b0, 3);
        add_frame(2'b10, 9, -1, 8'h00, 1'b1, 3, -1, 1'b0, 3);
        add_frame(2'b10, 8, -1, 8'h00, 1'b1, 3, -1, 1'b0, 3);
        add_frame(2'b00, 16, -1, 8'h00, 1'b1, 2, -1, 1'b0, 3);
        // Odd trailing nibble, single-byte frame, SFD-only frame, preamble cut short.
        add_frame(2'b11, 15, -1, 8'h00, 1'b1, 3, -1, 1'b1, 3);
        add_frame(2'b10, 7, -1, 8'h00, 1'b1, 1, -1, 1'b0, 2);
        add_frame(2'b10, 7, -1, 8'h00, 1'b1, 0, -1, 1'b0, 2);
        add_frame(2'b01, 6, -1, 8'h00, 1'b0, 0, -1, 1'b0, 2);
        run_q();

        // Reset mid-frame, released with dv still high: nothing may be accepted until dv drops.
        for (int j = 0; j < 6; j++) pbuf[j] = 8'($urandom);
        add_frame(2'b10, 7, -1, 8'h00, 1'b1, 6, -1, 1'b0, 2);
        for (int i = 0; i < 12; i++) apply(q[i]);
        q.delete();
        #2 rst_n = 1'b0;
        #1;
        chk_reset_state();
        m_frames = 0; m_errs = 0; m_up = 1'b0; m_spd = '0; m_dup = 1'b0;
        gmii_rx_dv = 1'b1; gmii_rxd = 8'h55;
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b1;
        q.push_back(mk(2'b10, 1'b1, 1'b0, 8'h55));
        q.push_back(mk(2'b10, 1'b1, 1'b0, 8'hD5));
        q.push_back(mk(2'b10, 1'b1, 1'b0, 8'h11));
        q.push_back(mk(2'b10, 1'b1, 1'b0, 8'h22));
        q.push_back(mk(2'b10, 1'b0, 1'b0, 8'h00));
        for (int f = 0; f < 5; f++) begin
            for (int j = 0; j < 4; j++) pbuf[j] = 8'($urandom);
            add_frame(2'b10, 7, -1, 8'h00, 1'b1, 4, -1, 1'b0, 2);
        end
        run_q();
        chk("sat_hold", s_frame_cnt, 2'd3);
        chk("after_rst_frames", frame_cnt, 5);

        for (int f = 0; f < 150; f++) begin
            spd = 2'($urandom);
            nib = (spd != 2'b10);
            npre = ($urandom_range(0, 9) < 6) ? (nib ? 15 : 7) : (nib ? $urandom_range(0, 17) : $urandom_range(0, 9));
            bad_at = -1;
            if (npre > 0 && $urandom_range(0, 7) == 0) bad_at = $urandom_range(0, npre - 1);
            do bs = 8'($urandom);
            while (nib ? (bs[3:0] == 4'h5 || bs[3:0] == 4'hD) : (bs == 8'h55 || bs == 8'hD5));
            sfd = ($urandom_range(0, 15) != 0);
            n = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 6);
            odd = nib && ($urandom_range(0, 3) == 0);
            er_at = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 12) : -1;
            for (int j = 0; j < n; j++) pbuf[j] = 8'($urandom);
            add_frame(spd, npre, bad_at, bs, sfd, n, er_at, odd, $urandom_range(1, 4));
        end
        run_q();

`ifdef GMII_RX_INBAND_STATUS_EN
        q.push_back(mk(2'b10, 1'b0, 1'b0, 8'h0D));
        run_q();
        chk("inband_0d", {link_up, link_speed, link_duplex}, 4'b1101);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
